piso_shiftreg: RTL and testbench

- Parallel-in, serial-out shift register; the transmit-side counterpart of the team's serial-in/parallel-out `shiftreg`.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per bit-period on `databit`; the bit-period comes from an internal tick divider.
- Used by top-level LED/IO demos to drive a serial line into a `shiftreg` instance, or off-chip.

---
 rtl/shiftreg_pkg.sv | 19 +
 rtl/tick_div.sv | 32 +++
 rtl/piso_shiftreg.sv | 138 +++++++++++++
 tb/tb_piso_shiftreg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared definitions for the shiftreg family (SIPO shiftreg, PISO piso_shiftreg).
// The PARITY state is only used when PISO_PARITY_EN is defined.
package shiftreg_pkg;

  localparam int SHIFTREG_WIDTH   = 4;
  localparam int SHIFTREG_TICKDIV = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } shiftreg_state_e;

  // Even parity bit; callers zero-extend narrower words.
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Clock-enable divider: counts 0..TICKDIV-1 while enabled and asserts tick
// on the terminal count; synchronous clear has priority over counting.
module tick_div
  import shiftreg_pkg::*;
#(
  parameter int TICKDIV = SHIFTREG_TICKDIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int TW = $clog2(TICKDIV + 1);
  localparam logic [TW-1:0] TERM = TW'(TICKDIV - 1);

  logic [TW-1:0] cnt;

  assign tick = (cnt == TERM);

  // The wrap takes precedence over the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (en) begin
      if (tick)       cnt <= '0;
      else            cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/piso_shiftreg.sv
// Parallel-in serial-out shift register with valid/ready load and tick-divided bit rate.
// Optional PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_shiftreg
  import shiftreg_pkg::*;
#(
  parameter int WIDTH     = SHIFTREG_WIDTH,
  parameter int TICKDIV   = SHIFTREG_TICKDIV,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] datain,
  output logic             databit,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  shiftreg_state_e state, nstate;
  logic [WIDTH-1:0] sreg, sreg_nxt, din_first;
  logic [BW-1:0]    bitcnt;
  logic             tick, last_bit, first_bit, next_bit;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  tick_div #(.TICKDIV(TICKDIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .en   (state != IDLE),
    .tick (tick)
  );

  assign last_bit  = (bitcnt == LAST);
  assign sreg_nxt  = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
  assign din_first = datain;
  assign first_bit = (MSB_FIRST != 0) ? din_first[WIDTH-1] : din_first[0];
  assign next_bit  = (MSB_FIRST != 0) ? sreg_nxt[WIDTH-1] : sreg_nxt[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate     = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) nstate = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (tick && last_bit) begin
`ifdef PISO_PARITY_EN
          nstate = PARITY;
`else
          done   = 1'b1;
          nstate = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        busy = 1'b1;
        if (tick) begin
          done   = 1'b1;
          nstate = IDLE;
        end
      end
`endif
      default: nstate = IDLE;
    endcase
  end

  // databit and bit_strobe are registered so each new bit and its strobe
  // appear together in the first cycle of the bit-period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg       <= '0;
      bitcnt     <= '0;
      databit    <= 1'b0;
      bit_strobe <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      bit_strobe <= 1'b0;
      case (state)
        IDLE: begin
          databit <= 1'b0;
          if (load_valid) begin
            sreg       <= datain;
            bitcnt     <= '0;
            databit    <= first_bit;
            bit_strobe <= 1'b1;
`ifdef PISO_PARITY_EN
            par_q      <= parity(64'(datain));
`endif
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!last_bit) begin
              sreg       <= sreg_nxt;
              bitcnt     <= bitcnt + BW'(1);
              databit    <= next_bit;
              bit_strobe <= 1'b1;
            end else begin
`ifdef PISO_PARITY_EN
              databit    <= par_q;
              bit_strobe <= 1'b1;
`else
              databit    <= 1'b0;
`endif
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (tick) databit <= 1'b0;
        end
`endif
        default: databit <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shiftreg.sv
// Directed bench for piso_shiftreg: three instances (MSB/TICKDIV=5, LSB/TICKDIV=5,
// MSB/TICKDIV=1) driven from a vector table plus hand-written corner sequences.
module tb_piso_shiftreg;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] lv;
  logic [3:0] din;
  logic [2:0] lr, db, bs, bz, dn;

  int n_cmp = 0;
  int n_bad = 0;
  int TD [3] = '{5, 5, 1};

  always #5 clk = ~clk;

  piso_shiftreg #(.WIDTH(4), .TICKDIV(5), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]), .datain(din),
    .databit(db[0]), .bit_strobe(bs[0]), .busy(bz[0]), .done(dn[0]));
  piso_shiftreg #(.WIDTH(4), .TICKDIV(5), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]), .datain(din),
    .databit(db[1]), .bit_strobe(bs[1]), .busy(bz[1]), .done(dn[1]));
  piso_shiftreg #(.WIDTH(4), .TICKDIV(1), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(lr[2]), .datain(din),
    .databit(db[2]), .bit_strobe(bs[2]), .busy(bz[2]), .done(dn[2]));

  typedef struct {
    int         sel;
    logic [3:0] d;
    logic [3:0] seq;  // expected bits, first transmitted at [3]
    logic       p;    // expected even parity of d
    string      nm;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input int s, input string nm);
    chk({nm, " load_ready"}, lr[s], 1'b1);
    chk({nm, " busy"},       bz[s], 1'b0);
    chk({nm, " databit"},    db[s], 1'b0);
    chk({nm, " done"},       dn[s], 1'b0);
    chk({nm, " strobe"},     bs[s], 1'b0);
  endtask

  // Accept one word on instance s and check every cycle through the idle cycle after done.
  task automatic run_word(input vec_t v);
    int td, len, b;
    logic eb;
    string t;
    td  = TD[v.sel];
    len = (4 + PAR) * td;
    @(negedge clk);
    chk({v.nm, " ready before accept"}, lr[v.sel], 1'b1);
    din = v.d;
    lv[v.sel] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == 1) begin
        lv[v.sel] = 1'b0;
        din = ~v.d;
      end
      b  = (c - 1) / td;
      eb = (b < 4) ? v.seq[3 - b] : v.p;
      t  = $sformatf("%s c%0d", v.nm, c);
      chk({t, " databit"}, db[v.sel], eb);
      chk({t, " strobe"},  bs[v.sel], ((c - 1) % td) == 0);
      chk({t, " busy"},    bz[v.sel], 1'b1);
      chk({t, " ready"},   lr[v.sel], 1'b0);
      chk({t, " done"},    dn[v.sel], c == len);
    end
    @(negedge clk);
    chk_idle(v.sel, {v.nm, " after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 4'b1011, 4'b1011, 1'b1, "msb_1011"};
    vt[1] = '{0, 4'b0111, 4'b0111, 1'b1, "msb_0111"};
    vt[2] = '{1, 4'b1000, 4'b0001, 1'b1, "lsb_1000"};
    vt[3] = '{1, 4'b0110, 4'b0110, 1'b0, "lsb_0110"};
    vt[4] = '{2, 4'b1010, 4'b1010, 1'b0, "td1_1010"};
    vt[5] = '{2, 4'b0101, 4'b0101, 1'b0, "td1_0101"};

    // Reset held with load_valid high: nothing may be accepted.
    rst = 1'b0;
    lv  = 3'b111;
    din = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) chk_idle(s, $sformatf("reset%0d i%0d", i, s));
    end
    lv  = 3'b000;
    rst = 1'b1;

    for (int k = 0; k < 6; k++) run_word(vt[k]);

    // TICKDIV=1 with load_valid held: A, one idle cycle, then 5.
    begin
      int   len;
      logic eb, er, ed;
      logic [3:0] wa, wb;
      wa  = 4'hA;
      wb  = 4'h5;
      len = 4 + PAR;
      @(negedge clk);
      din   = wa;
      lv[2] = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 2 * len + 1; i++) begin
        @(negedge clk);
        if (i == 1) din = wb;
        if (i == 2 * len + 1) lv[2] = 1'b0;
        er = (i == len + 1);
        ed = (i == len) || (i == 2 * len + 1);
        if (i <= 4)               eb = wa[4 - i];
        else if (i <= len)        eb = 1'b0;
        else if (i == len + 1)    eb = 1'b0;
        else if (i <= len + 5)    eb = wb[len + 5 - i];
        else                      eb = 1'b0;
        chk($sformatf("stream c%0d databit", i), db[2], eb);
        chk($sformatf("stream c%0d ready", i),   lr[2], er);
        chk($sformatf("stream c%0d done", i),    dn[2], ed);
      end
      @(negedge clk);
      chk_idle(2, "stream after");
    end

    // Mid-word reset at cycle 7 of 4'b1101 on the TICKDIV=5 MSB instance.
    @(negedge clk);
    din   = 4'b1101;
    lv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lv[0] = 1'b0;
    for (int c = 2; c <= 6; c++) @(negedge clk);
    @(posedge clk);
    #2;
    chk("abort pre databit", db[0], 1'b1);
    rst = 1'b0;
    #1;
    chk_idle(0, "abort async");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_idle(0, $sformatf("abort hold%0d", i));
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("abort no done c%0d", i), dn[0], 1'b0);
    end
    begin
      vec_t vf;
      vf = '{0, 4'hF, 4'hF, 1'b0, "post_abort_F"};
      run_word(vf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
